// File: rtl/mux_scan_capture_if.sv
// Handshake and mux-select bundle between the scan/capture stage and its mux and consumer.
// The slave side is the capture block; the master side is the mux model and the consumer.
interface mux_scan_capture_if #(
    parameter int unsigned SEL_W = 2
) ();
    localparam int unsigned WIDTH = 2 ** SEL_W;

    logic             start;
    logic             y;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic [WIDTH-1:0] word;
    logic             valid;
    logic             ready;

    modport slave (
        input  start, y, ready,
        output sel, busy, word, valid
    );

    modport master (
        output start, y, ready,
        input  sel, busy, word, valid
    );
endinterface

// File: rtl/mux_scan_capture.sv
// Steps the mux select through 0..WIDTH-1 and samples y once per value.
// The assembled word is offered to the consumer over a valid/ready handshake.
module mux_scan_capture #(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mux_scan_capture_if.slave io_bus
);
    localparam int unsigned WIDTH = 2 ** SEL_W;
    localparam int unsigned CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC);

    typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

    state_e           r_state, w_state;
    logic [SEL_W-1:0] r_sel, w_sel;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [WIDTH-1:0] r_asm, w_asm;
    logic [WIDTH-1:0] r_word, w_word;
    logic             r_busy, w_busy;
    logic             r_valid, w_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_cnt   <= w_cnt;
            r_asm   <= w_asm;
            r_word  <= w_word;
            r_busy  <= w_busy;
            r_valid <= w_valid;
        end
    end

    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_cnt   = r_cnt;
        w_asm   = r_asm;
        w_word  = r_word;
        unique case (r_state)
            StIdle: begin
                w_sel = '0;
                if (io_bus.start) begin
                    w_state = StScan;
                    w_cnt   = CNT_INIT;
                    w_asm   = '0;
                end
            end
            StScan: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_asm[r_sel] = io_bus.y;
                    if (r_sel == SEL_LAST) begin
                        // Word is published whole, including the bit sampled on this edge.
                        w_word  = w_asm;
                        w_sel   = '0;
                        w_state = StHold;
                    end else begin
                        w_sel = r_sel + 1'b1;
                        w_cnt = CNT_INIT;
                    end
                end
            end
            StHold: begin
                w_sel = '0;
                if (io_bus.ready) begin
                    if (io_bus.start) begin
                        w_state = StScan;
                        w_cnt   = CNT_INIT;
                        w_asm   = '0;
                    end else begin
                        w_state = StIdle;
                    end
                end
            end
            default: begin
                w_state = StIdle;
                w_sel   = '0;
            end
        endcase
        w_busy  = (w_state == StScan);
        w_valid = (w_state == StHold);
    end

    assign io_bus.sel   = r_sel;
    assign io_bus.busy  = r_busy;
    assign io_bus.word  = r_word;
    assign io_bus.valid = r_valid;
endmodule
